// File: rtl/exec_mem_pkg.sv
// Shared encodings for the execute/memory slice: ALU control codes and
// the ALUOp values produced by main control.
package exec_mem_pkg;

    // ALU control codes seen on alu_ctrl
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    // ALUOp from main control; 2'b11 is not named and decodes as ADD
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    // {instr[30], funct3} patterns recognised for R-type decode
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b1000;
    localparam logic [3:0] FN_AND = 4'b0111;
    localparam logic [3:0] FN_OR  = 4'b0110;
    localparam logic [3:0] FN_XOR = 4'b0100;
    localparam logic [3:0] FN_SLL = 4'b0001;
    localparam logic [3:0] FN_SRL = 4'b0101;
    localparam logic [3:0] FN_SRA = 4'b1101;
    localparam logic [3:0] FN_SLT = 4'b0010;

endpackage

// File: rtl/exec_alu.sv
// 64-bit combinational ALU with zero and signed-overflow flags.
module exec_alu
    import exec_mem_pkg::*;
(
    input  logic [3:0]  alu_ctrl,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output logic        zero,
    output logic        overflow
);

    logic [5:0] shamt;
    logic       a_lt_b;

    assign shamt  = b[5:0];
    assign a_lt_b = $signed(a) < $signed(b);

    // Result select; codes outside the defined set produce zero
    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SUB: result = a - b;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            ALU_SLT: result = {63'b0, a_lt_b};
            default: result = '0;
        endcase
    end

    // Flags: overflow only has meaning for the add/sub paths
    always_comb begin
        zero     = (result == '0);
        overflow = 1'b0;
        if (alu_ctrl == ALU_ADD) begin
            overflow = (a[63] == b[63]) && (result[63] != a[63]);
        end else if (alu_ctrl == ALU_SUB) begin
            overflow = (a[63] != b[63]) && (result[63] != a[63]);
        end
    end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: ALU-control decode, ALU, and a doubleword data
// memory indexed by the ALU result.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  alu_op,
    input  logic [3:0]  funct,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] write_data,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] alu_result,
    output logic        zero,
    output logic        overflow,
    output logic [63:0] read_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0]      mem_q [MEM_WORDS];
    logic [63:0]      mem_d [MEM_WORDS];
    logic [IDX_W-1:0] idx;

    // ALU-control decode from ALUOp and {instr[30], funct3}
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_MEM: alu_ctrl = ALU_ADD;
            ALUOP_BR:  alu_ctrl = ALU_SUB;
            ALUOP_R: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_XOR:  alu_ctrl = ALU_XOR;
                    FN_SLL:  alu_ctrl = ALU_SLL;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    FN_SRA:  alu_ctrl = ALU_SRA;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default:   alu_ctrl = ALU_ADD;
        endcase
    end

    exec_alu u_alu (
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .result   (alu_result),
        .zero     (zero),
        .overflow (overflow)
    );

    // Byte address -> doubleword index; low 3 bits and upper bits dropped
    assign idx = alu_result[IDX_W+2:3];

    // Combinational load port, gated to zero when not reading
    always_comb begin
        read_data = '0;
        if (mem_read) begin
            read_data = mem_q[idx];
        end
    end

    // Next memory image: one word replaced on a store
    always_comb begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (mem_write) begin
            mem_d[idx] = write_data;
        end
    end

    // Memory array; asynchronous reset wipes every word and drops any store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: directed cases followed by random traffic
// compared against a behavioural model of decode, ALU and memory.
module tb_exec_mem_unit;

    localparam int MEM_WORDS = 32;

    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                  OP_SLL, OP_SRL, OP_SRA, OP_SLT} op_e;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [63:0] a, b;
    logic        mem_read, mem_write;
    logic [63:0] write_data;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic        zero, overflow;
    logic [63:0] read_data;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] ref_mem [MEM_WORDS];

    exec_mem_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_op     (alu_op),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero),
        .overflow   (overflow),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Which operation the instruction fields ask for
    function automatic op_e model_op(input logic [1:0] op, input logic [3:0] f);
        if (op == 2'b01) return OP_SUB;
        if (op != 2'b10) return OP_ADD;
        case (f)
            4'b1000: return OP_SUB;
            4'b0111: return OP_AND;
            4'b0110: return OP_OR;
            4'b0100: return OP_XOR;
            4'b0001: return OP_SLL;
            4'b0101: return OP_SRL;
            4'b1101: return OP_SRA;
            4'b0010: return OP_SLT;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic [3:0] model_code(input op_e o);
        case (o)
            OP_AND:  return 4'b0000;
            OP_OR:   return 4'b0001;
            OP_ADD:  return 4'b0010;
            OP_XOR:  return 4'b0011;
            OP_SLL:  return 4'b0100;
            OP_SRL:  return 4'b0101;
            OP_SUB:  return 4'b0110;
            OP_SRA:  return 4'b0111;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [63:0] model_res(input op_e o, input logic [63:0] x, input logic [63:0] y);
        int sh;
        logic [63:0] r;
        sh = int'(y[5:0]);
        case (o)
            OP_ADD: r = x + y;
            OP_SUB: r = x - y;
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_SLL: r = x << sh;
            OP_SRL: r = x >> sh;
            OP_SRA: begin
                r = x >> sh;
                if (x[63]) r = r | ~({64{1'b1}} >> sh);
            end
            default: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
        endcase
        return r;
    endfunction

    // True signed result out of the 64-bit range means overflow
    function automatic logic model_ovf(input op_e o, input logic [63:0] x, input logic [63:0] y);
        logic [64:0] wide;
        if (o == OP_ADD) wide = {x[63], x} + {y[63], y};
        else if (o == OP_SUB) wide = {x[63], x} - {y[63], y};
        else return 1'b0;
        return wide[64] != wide[63];
    endfunction

    function automatic int model_idx(input logic [63:0] addr);
        return int'((addr / 64'd8) % 64'(MEM_WORDS));
    endfunction

    task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic [63:0] x,
                         input logic [63:0] y, input logic rd, input logic wr, input logic [63:0] wd);
        alu_op = op; funct = f; a = x; b = y;
        mem_read = rd; mem_write = wr; write_data = wd;
        #1;
    endtask

    // Compare every output against the model for the current inputs
    task automatic chk_all(input string tag);
        op_e o;
        logic [63:0] r;
        o = model_op(alu_op, funct);
        r = model_res(o, a, b);
        chk({tag, ".ctrl"}, 64'(alu_ctrl), 64'(model_code(o)));
        chk({tag, ".res"},  alu_result, r);
        chk({tag, ".zero"}, 64'(zero), 64'(r == 64'd0));
        chk({tag, ".ovf"},  64'(overflow), 64'(model_ovf(o, a, b)));
        chk({tag, ".rd"},   read_data, mem_read ? ref_mem[model_idx(r)] : 64'd0);
    endtask

    task automatic tick();
        logic [63:0] r;
        @(posedge clk);
        r = model_res(model_op(alu_op, funct), a, b);
        if (rst_n && mem_write) ref_mem[model_idx(r)] = write_data;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 64'd0;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        drive(2'b00, 4'b0000, 64'd16, 64'd8, 1'b1, 1'b0, 64'd0);
        chk("reset_rd", read_data, 64'd0);
        tick();
        chk("reset_rd2", read_data, 64'd0);
        #2 rst_n = 1'b1;
        tick();

        drive(2'b10, 4'b1000, 64'd10, 64'd3, 1'b0, 1'b0, 64'd0);
        chk("sub_ctrl", 64'(alu_ctrl), 64'h6);
        chk("sub_res", alu_result, 64'd7);
        chk("sub_zero", 64'(zero), 64'd0);
        chk("sub_ovf", 64'(overflow), 64'd0);

        drive(2'b10, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0);
        chk("add_res", alu_result, 64'h8000_0000_0000_0000);
        chk("add_ovf", 64'(overflow), 64'd1);

        drive(2'b01, 4'b0000, 64'd42, 64'd42, 1'b0, 1'b0, 64'd0);
        chk("beq_ctrl", 64'(alu_ctrl), 64'h6);
        chk("beq_res", alu_result, 64'd0);
        chk("beq_zero", 64'(zero), 64'd1);

        drive(2'b00, 4'b0000, 64'd16, 64'd8, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        tick();
        drive(2'b00, 4'b0000, 64'd16, 64'd8, 1'b1, 1'b0, 64'd0);
        chk("ld24", read_data, 64'hDEAD_BEEF_0000_0001);
        drive(2'b00, 4'b0000, 64'd19, 64'd8, 1'b1, 1'b0, 64'd0);
        chk("ld27", read_data, 64'hDEAD_BEEF_0000_0001);
        drive(2'b00, 4'b0000, 64'd16 + 64'(MEM_WORDS * 8), 64'd8, 1'b1, 1'b0, 64'd0);
        chk("ld_wrap", read_data, 64'hDEAD_BEEF_0000_0001);

        drive(2'b00, 4'b0000, 64'd16, 64'd0, 1'b0, 1'b1, 64'd5);
        tick();
        drive(2'b00, 4'b0000, 64'd16, 64'd0, 1'b1, 1'b1, 64'd9);
        chk("rw_before", read_data, 64'd5);
        tick();
        chk("rw_after", read_data, 64'd9);
        drive(2'b00, 4'b0000, 64'd16, 64'd0, 1'b0, 1'b0, 64'd0);
        chk("rd_off", read_data, 64'd0);

        drive(2'b00, 4'b0000, 64'd0, 64'd0, 1'b0, 1'b1, 64'h55);
        tick();
        drive(2'b00, 4'b0000, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        chk("pre_rst", read_data, 64'h55);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_clear", read_data, 64'd0);
        drive(2'b00, 4'b0000, 64'd0, 64'd0, 1'b1, 1'b1, 64'h77);
        tick();
        #2 rst_n = 1'b1;
        drive(2'b00, 4'b0000, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        chk("rst_wr_drop", read_data, 64'd0);
        drive(2'b00, 4'b0000, 64'd24, 64'd0, 1'b1, 1'b0, 64'd0);
        chk("rst_other", read_data, 64'd0);

        drive(2'b10, 4'b1101, -64'sd16, 64'd2, 1'b0, 1'b0, 64'd0);
        chk("sra_res", alu_result, -64'sd4);
        drive(2'b10, 4'b0010, -64'sd1, 64'd1, 1'b0, 1'b0, 64'd0);
        chk("slt_res", alu_result, 64'd1);

        for (int it = 0; it < 400; it++) begin
            logic [1:0]  op;
            logic [63:0] x, y;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                op = 2'b00;
                x  = 64'($urandom_range(0, 511));
                y  = 64'($urandom_range(0, 63));
            end else begin
                x = {$urandom, $urandom};
                y = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0: y = x;
                    1: x = {x[63], 63'h7FFF_FFFF_FFFF_FFF0 | 63'(x[3:0])};
                    default: ;
                endcase
            end
            drive(op, 4'($urandom), x, y, 1'($urandom), ($urandom_range(0, 9) < 4),
                  {$urandom, $urandom});
            chk_all("rnd");
            tick();
            chk_all("rnd_post");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
Execute/memory slice of the single-cycle RV64 datapath. It contains three parts:
- the ALU-control decoder (ALUOp plus {instr[30], funct3} to a 4-bit ALU control code);
- a 64-bit ALU with zero and signed-overflow flags;
- a doubleword data memory addressed by the ALU result.
It sits between the register file/immediate mux and the write-back mux; the PC/branch logic consumes its zero flag.

Parameters:
MEM_WORDS, 32, number of 64-bit doublewords in the data memory (power of two).
IDX_W, $clog2(MEM_WORDS), derived doubleword index width (localparam).

Ports:
clk  in  1  system clock; memory writes occur on its rising edge
rst_n  in  1  asynchronous active-low reset
alu_op  in  2  ALUOp from main control
funct  in  4  {instr[30], instr[14:12]}
a  in  64  operand A (rs1), signed
b  in  64  operand B (rs2 or immediate), signed
mem_read  in  1  data-memory read enable
mem_write  in  1  data-memory write enable
write_data  in  64  store data (rs2)
alu_ctrl  out  4  decoded ALU control code
alu_result  out  64  ALU result; also the memory byte address
zero  out  1  alu_result == 0
overflow  out  1  signed overflow for ADD/SUB
read_data  out  64  load data

Behaviour:
ALU control is combinational.
- alu_op 00 -> ADD (0010), used by ld/sd.
- alu_op 01 -> SUB (0110), used by beq.
- alu_op 11 -> ADD (0010).
- alu_op 10 decodes funct:
  - 0000 ADD 0010
  - 1000 SUB 0110
  - 0111 AND 0000
  - 0110 OR 0001
  - 0100 XOR 0011
  - 0001 SLL 0100
  - 0101 SRL 0101
  - 1101 SRA 0111
  - 0010 SLT 1000
  - any other funct -> ADD 0010

ALU is combinational, 64-bit two's complement.
- ADD a+b, SUB a-b; both wrap modulo 2^64.
- AND, OR, XOR are bitwise.
- SLL, SRL, SRA shift a by b[5:0]; SRA is arithmetic.
- SLT gives 1 if signed a < b, else 0.
- Undefined alu_ctrl codes give result 0.
- zero = (alu_result == 0) for every operation.
- overflow: ADD sets it when a and b have the same sign and the result sign differs. SUB sets it when a and b have different signs and the result sign differs from a. It is 0 for all other operations.

Data memory:
- MEM_WORDS x 64-bit array. The index is alu_result[IDX_W+2:3].
- Low 3 address bits are ignored (forced doubleword alignment). Upper bits are ignored, so addresses wrap modulo MEM_WORDS*8.
- Read is combinational: read_data = mem[idx] when mem_read=1, else 64'h0.
- Write is synchronous: on posedge clk with mem_write=1, mem[idx] <= write_data.
- Read and write to the same index in one cycle: read_data shows the old contents until the edge, then the new value.
- mem_read=1 and mem_write=1 together is legal; both actions occur.

Reset:
- rst_n low asynchronously clears every memory word to 0, including mid-cycle; a write at that edge is discarded.
- Writes are blocked while rst_n=0.
- The combinational outputs have no reset state. During reset read_data = 0 when mem_read=1, because memory is cleared.

Latency: all outputs are combinational from inputs in the same cycle; store data is visible one edge later.

Decomposition:
- Package exec_mem_pkg holds:
  - ALU control code localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SRA, ALU_SLT;
  - ALUOp encodings: ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10.
- Sub-module exec_alu holds the ALU and its flags. The decoder and the memory stay inline in exec_mem_unit.

Test Plan:
- alu_op=10, funct=1000, a=10, b=3 -> alu_ctrl=0110, alu_result=7, zero=0, overflow=0.
- alu_op=10, funct=0000, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> alu_result=64'h8000_0000_0000_0000, overflow=1.
- alu_op=01, a=b=42 -> alu_ctrl=0110, alu_result=0, zero=1.
- Store then load:
  - set alu_op=00, a=16, b=8, write_data=64'hDEAD_BEEF_0000_0001, mem_write=1, one posedge, then mem_write=0, mem_read=1 -> read_data=64'hDEAD_BEEF_0000_0001 at address 24;
  - address 27 reads the same word;
  - address 24+MEM_WORDS*8 reads the same word (wrap).
- Same-cycle read/write to index 2 holding 5, writing 9 -> read_data=5 before the edge, 9 after. With mem_read=0 -> read_data=0.
- Store 64'h55 to address 0, pulse rst_n low between clock edges -> mem[0] cleared immediately, read_data=0; a write asserted during reset is dropped.
- Shifts and SLT:
  - alu_op=10, SRA (funct=1101), a=-16, b=2 -> result -4;
  - SLT (funct=0010), a=-1, b=1 -> 1.
